// File: rtl/rf_pkg.sv
// rf_pkg: default geometry and shared helpers for the multiport register file
package rf_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH_DEF      = 32;

    function automatic logic [7:0] merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic strb);
        if (strb) return new_b;
        return old_b;
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr, input int depth, input logic zero_reg);
        return (addr < 32'(depth)) && !(zero_reg && addr == 32'd0);
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port; RF_WRITE_FWD_EN adds same-cycle write forwarding
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter bit ZERO_REG   = 1'b1
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    READ,
    input  logic [ADDR_WIDTH-1:0]   ADDR,
    input  logic [DATA_WIDTH-1:0]   ENTRY,
`ifdef RF_WRITE_FWD_EN
    input  logic                    WR_EN,
    input  logic [ADDR_WIDTH-1:0]   ADDR_W,
    input  logic [DATA_WIDTH-1:0]   DATA_W,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   DATA_R,
    output logic                    VALID_R
);
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_next;

`ifdef RF_WRITE_FWD_EN
    // overlay strobed bytes of an effective same-address write onto the stored entry
    always_comb begin
        rd_word = ENTRY;
        if (WR_EN && ADDR == ADDR_W)
            for (int k = 0; k < DATA_WIDTH/8; k++)
                rd_word[8*k +: 8] = merge(ENTRY[8*k +: 8], DATA_W[8*k +: 8], WSTRB[k]);
    end
`else
    assign rd_word = ENTRY;
`endif

    assign rd_next = addr_ok(32'(ADDR), DEPTH, ZERO_REG) ? rd_word : '0;

    // output register: load on read, hold data and drop VALID when idle
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            DATA_R  <= '0;
            VALID_R <= 1'b0;
        end else if (READ) begin
            DATA_R  <= rd_next;
            VALID_R <= 1'b1;
        end else
            VALID_R <= 1'b0;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: byte-strobed register file with NUM_RD registered read ports (RF_WRITE_FWD_EN enables write forwarding)
module regfile_multiport
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int NUM_RD     = 2,
    parameter bit ZERO_REG   = 1'b1
)(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WRITE,
    input  logic [ADDR_WIDTH-1:0]        ADDR_W,
    input  logic [DATA_WIDTH-1:0]        DATA_W,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic [NUM_RD-1:0]            READ,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ADDR_R,
    output logic [NUM_RD*DATA_WIDTH-1:0] DATA_R,
    output logic [NUM_RD-1:0]            VALID_R
);
    generate
        if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("regfile_multiport: DATA_WIDTH must be a positive multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
            $error("regfile_multiport: DEPTH must be in 1..2**ADDR_WIDTH");
        end
        if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_ports
            $error("regfile_multiport: NUM_RD must be in 1..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;

    assign wr_en = WRITE && addr_ok(32'(ADDR_W), DEPTH, ZERO_REG);

    // storage: cleared on reset, strobed bytes merged in on an effective write
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < DATA_WIDTH/8; k++)
                mem[ADDR_W][8*k +: 8] <= merge(mem[ADDR_W][8*k +: 8], DATA_W[8*k +: 8], WSTRB[k]);
        end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            rf_read_port #(
                .DATA_WIDTH(DATA_WIDTH),
                .ADDR_WIDTH(ADDR_WIDTH),
                .DEPTH     (DEPTH),
                .ZERO_REG  (ZERO_REG)
            ) u_rd (
                .CLK    (CLK),
                .RST    (RST),
                .READ   (READ[p]),
                .ADDR   (ADDR_R[p*ADDR_WIDTH +: ADDR_WIDTH]),
                .ENTRY  (mem[ADDR_R[p*ADDR_WIDTH +: ADDR_WIDTH]]),
`ifdef RF_WRITE_FWD_EN
                .WR_EN  (wr_en),
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W),
                .WSTRB  (WSTRB),
`endif
                .DATA_R (DATA_R[p*DATA_WIDTH +: DATA_WIDTH]),
                .VALID_R(VALID_R[p])
            );
        end
    endgenerate
endmodule
